// File: rtl/modn_digit_counter.sv
// modn_digit_counter: parameterised multi-digit modulo-N counter.
//
// Each DIGIT_W-bit slice of q counts 0..MODULUS-1. Digit 0 is the least
// significant digit. Higher digits advance through a ripple-enable chain. The
// whole counter wraps from all-(MODULUS-1) to all-0 when counting up, and from
// all-0 to all-(MODULUS-1) when counting down.
//
// Ports:
//   clk    - clock; all state updates happen on the rising edge
//   reset  - asynchronous active-low reset; clears q and wrap
//   en     - count enable; clr and load act regardless of en
//   up     - direction: 1 counts up, 0 counts down
//   clr    - synchronous clear to zero; highest priority
//   load   - synchronous parallel load from din; out-of-range slices load as 0
//   din    - load value, packed like q
//   q      - registered count, one digit per DIGIT_W slice
//   tc     - combinational terminal count: the next enabled edge wraps
//   wrap   - registered pulse: the previous edge wrapped the whole counter
module modn_digit_counter #(
  parameter int unsigned MODULUS = 10,
  parameter int unsigned DIGIT_W = 4,
  parameter int unsigned DIGITS  = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       en,
  input  logic                       up,
  input  logic                       clr,
  input  logic                       load,
  input  logic [DIGITS*DIGIT_W-1:0]  din,
  output logic [DIGITS*DIGIT_W-1:0]  q,
  output logic                       tc,
  output logic                       wrap
);

  localparam int unsigned Width = DIGITS * DIGIT_W;
  localparam logic [DIGIT_W-1:0] MaxDigit = DIGIT_W'(MODULUS - 1);

  if (MODULUS < 2 || MODULUS > (1 << DIGIT_W)) begin : g_bad_modulus
    $error("modn_digit_counter: MODULUS must lie in 2..2**DIGIT_W");
  end
  if (DIGITS < 1) begin : g_bad_digits
    $error("modn_digit_counter: DIGITS must be at least 1");
  end

  logic [Width-1:0]  count_q, count_d;
  logic              wrap_q, wrap_d;
  logic [DIGITS-1:0] at_term;
  // ripple[k] is set when digits 0..k-1 are all terminal, i.e. digit k steps.
  logic [DIGITS:0]   ripple;

  // Out-of-range values behave as MaxDigit so they roll to 0 on the next step.
  function automatic logic [DIGIT_W-1:0] digit_inc(input logic [DIGIT_W-1:0] d);
    return (d >= MaxDigit) ? '0 : d + 1'b1;
  endfunction

  // A down step from an out-of-range value snaps back into range at MaxDigit.
  function automatic logic [DIGIT_W-1:0] digit_dec(input logic [DIGIT_W-1:0] d);
    if (d == '0 || d > MaxDigit) begin
      return MaxDigit;
    end
    return d - 1'b1;
  endfunction

  function automatic logic [DIGIT_W-1:0] digit_load(input logic [DIGIT_W-1:0] d);
    return (d > MaxDigit) ? '0 : d;
  endfunction

  // Terminal-value detection and the ripple-enable chain.
  always_comb begin
    at_term   = '0;
    ripple    = '0;
    ripple[0] = 1'b1;
    for (int k = 0; k < int'(DIGITS); k++) begin
      if (up) begin
        at_term[k] = (count_q[k*DIGIT_W +: DIGIT_W] >= MaxDigit);
      end else begin
        at_term[k] = (count_q[k*DIGIT_W +: DIGIT_W] == '0);
      end
      ripple[k+1] = ripple[k] & at_term[k];
    end
  end

  assign tc = en & ripple[DIGITS];

  // Next-state selection: clr > load > count > hold.
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (clr) begin
      count_d = '0;
    end else if (load) begin
      for (int k = 0; k < int'(DIGITS); k++) begin
        count_d[k*DIGIT_W +: DIGIT_W] = digit_load(din[k*DIGIT_W +: DIGIT_W]);
      end
    end else if (en) begin
      for (int k = 0; k < int'(DIGITS); k++) begin
        if (ripple[k]) begin
          if (up) begin
            count_d[k*DIGIT_W +: DIGIT_W] = digit_inc(count_q[k*DIGIT_W +: DIGIT_W]);
          end else begin
            count_d[k*DIGIT_W +: DIGIT_W] = digit_dec(count_q[k*DIGIT_W +: DIGIT_W]);
          end
        end
      end
      wrap_d = ripple[DIGITS];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign q    = count_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_modn_digit_counter.sv
module tb_modn_digit_counter;

  logic       clk = 1'b0;
  logic       reset;
  logic       en, up, clr, load;
  logic [7:0] din;
  logic [7:0] q;
  logic       tc, wrap;

  logic       en6, up6, clr6, load6;
  logic [8:0] din6;
  logic [8:0] q6;
  logic       tc6, wrap6;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  modn_digit_counter dut (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .up    (up),
    .clr   (clr),
    .load  (load),
    .din   (din),
    .q     (q),
    .tc    (tc),
    .wrap  (wrap)
  );

  modn_digit_counter #(
    .MODULUS (6),
    .DIGIT_W (3),
    .DIGITS  (3)
  ) dut6 (
    .clk   (clk),
    .reset (reset),
    .en    (en6),
    .up    (up6),
    .clr   (clr6),
    .load  (load6),
    .din   (din6),
    .q     (q6),
    .tc    (tc6),
    .wrap  (wrap6)
  );

  typedef struct {
    logic       clr;
    logic       load;
    logic       en;
    logic       up;
    logic [7:0] din;
    logic       exp_tc;   // tc with these inputs, before the edge
    logic [7:0] exp_q;    // q after the edge
    logic       exp_wrap; // wrap after the edge
  } vec_t;

  localparam int NumVecs = 20;
  vec_t vecs[NumVecs];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] bcd(input int n);
    return {4'(n / 10), 4'(n % 10)};
  endfunction

  function automatic logic [8:0] b6(input int n);
    return {3'(n / 36), 3'((n / 6) % 6), 3'(n % 6)};
  endfunction

  task automatic drive(input logic c, input logic l, input logic e, input logic u,
                       input logic [7:0] d);
    clr  = c;
    load = l;
    en   = e;
    up   = u;
    din  = d;
  endtask

  initial begin
    // clr, load, en, up, din, exp_tc, exp_q, exp_wrap (start from q=00)
    vecs[0]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h57, 1'b0, 8'h57, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 8'h58, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 8'h59, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 8'h60, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'hA3, 1'b0, 8'h03, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h42, 1'b0, 8'h42, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h88, 1'b0, 8'h00, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h99, 1'b1};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h98, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h97, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'h99, 1'b0, 8'h99, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 8'h99, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 1'b1, 8'h00, 1'b1};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[15] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h9A, 1'b0, 8'h90, 1'b0};
    vecs[16] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 8'h91, 1'b0};
    vecs[17] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'hF9, 1'b0, 8'h09, 1'b0};
    vecs[18] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h08, 1'b0};
    vecs[19] = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0};

    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    en6 = 1'b0; up6 = 1'b1; clr6 = 1'b0; load6 = 1'b0; din6 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_q", 32'(q), 32'h00);
    check("reset_wrap", 32'(wrap), 32'h0);
    check("reset_tc", 32'(tc), 32'h0);
    @(negedge clk);
    reset = 1'b1;

    // Full up-count cycle 00..99..00.
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
      #1;
      check("up_tc", 32'(tc), 32'(i == 99));
      @(posedge clk);
      #1;
      check("up_q", 32'(q), 32'(bcd((i + 1) % 100)));
      check("up_wrap", 32'(wrap), 32'(i == 99));
    end

    // Directed vector table.
    for (int i = 0; i < NumVecs; i++) begin
      @(negedge clk);
      drive(vecs[i].clr, vecs[i].load, vecs[i].en, vecs[i].up, vecs[i].din);
      #1;
      check($sformatf("vec%0d_tc", i), 32'(tc), 32'(vecs[i].exp_tc));
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_q", i), 32'(q), 32'(vecs[i].exp_q));
      check($sformatf("vec%0d_wrap", i), 32'(wrap), 32'(vecs[i].exp_wrap));
    end

    // Asynchronous reset in mid-cycle from q=35.
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 8'h34);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
    @(posedge clk);
    #1;
    check("pre_reset_q", 32'(q), 32'h35);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("async_reset_q", 32'(q), 32'h00);
    check("async_reset_wrap", 32'(wrap), 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("held_reset_q", 32'(q), 32'h00);
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("resume_q", 32'(q), 32'h01);

    // Reset clears a pending wrap pulse without a clock edge.
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    @(posedge clk);
    #1;
    check("down_to_zero_q", 32'(q), 32'h00);
    @(posedge clk);
    #1;
    check("down_wrap_q", 32'(q), 32'h99);
    check("down_wrap_pulse", 32'(wrap), 32'h1);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    #2;
    reset = 1'b0;
    #1;
    check("async_reset_wrap_clear", 32'(wrap), 32'h0);
    check("async_reset_q2", 32'(q), 32'h00);
    @(negedge clk);
    reset = 1'b1;

    // MODULUS=6, DIGITS=3 sweep: 216 edges return to 000 with a wrap pulse.
    @(negedge clk);
    check("m6_start_q", 32'(q6), 32'h0);
    en6 = 1'b1;
    up6 = 1'b1;
    for (int i = 0; i < 216; i++) begin
      #1;
      if (i == 215) begin
        check("m6_555_q", 32'(q6), 32'(9'o555));
        check("m6_tc", 32'(tc6), 32'h1);
      end
      @(posedge clk);
      #1;
      check("m6_q", 32'(q6), 32'(b6((i + 1) % 216)));
      if (i >= 214) begin
        check("m6_wrap", 32'(wrap6), 32'(i == 215));
      end
      @(negedge clk);
    end
    en6 = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/modn_digit_counter.md
Name: modn_digit_counter

Overview:
- Parametrised, synchronous, multi-digit modulo-N counter; next generation of the team's single-digit mod-10 counter.
- Generalises the modulus, digit width and digit count.
- Adds enable, up/down counting, synchronous clear and parallel load, and terminal-count/wrap outputs so instances can be cascaded.
- Used as a decimal (or other radix) event/time counter feeding display and timing logic.

Parameters:
- MODULUS, 10, count range per digit 0..MODULUS-1; legal range 2..2**DIGIT_W.
- DIGIT_W, 4, bits per digit.
- DIGITS, 2, number of cascaded digits; digit 0 is least significant, at q[DIGIT_W-1:0].

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset; asserts immediately, deasserts synchronously to clk by the integrator.
- en  input  1  count enable; when 0, value holds (clear/load still act).
- up  input  1  direction: 1 counts up, 0 counts down.
- clr  input  1  synchronous clear to all-zero.
- load  input  1  synchronous parallel load from din.
- din  input  DIGITS*DIGIT_W  load value, packed like q.
- q  output  DIGITS*DIGIT_W  current count, one digit per DIGIT_W slice; registered.
- tc  output  1  terminal count, combinational: en=1 and every digit is at the terminal value for the current direction (MODULUS-1 when up=1, 0 when up=0).
- wrap  output  1  registered one-cycle pulse: the previous edge wrapped the whole counter.

Behaviour:
- reset=0: q=0 and wrap=0 immediately, independent of clk. Held while reset=0.
- Priority per rising edge, reset released: clr > load > en-count > hold.
- clr=1: q=0, wrap=0.
- load=1 (clr=0): each digit takes its din slice. Any slice >= MODULUS loads as 0; other digits are unaffected. wrap=0.
- Count up (en=1, up=1):
  - Digit 0 increments.
  - Digit k increments only when digits 0..k-1 are all MODULUS-1 (ripple carry, evaluated combinationally within the same cycle).
  - A digit at MODULUS-1 that increments becomes 0.
- Count down (en=1, up=0): mirror of count up. A digit decrements when all lower digits are 0; a digit at 0 that decrements becomes MODULUS-1.
- Whole-counter wrap: up from all-(MODULUS-1) to all-0, or down from all-0 to all-(MODULUS-1). On the edge that performs the wrap, wrap is set to 1; it clears on the next edge unless another wrap occurs (only possible when MODULUS**DIGITS = 1, which is illegal).
- en=0 with no clr/load: q holds, wrap=0 on the next edge; tc=0.
- Direction change takes effect on the same edge as sampled; there is no pipelining.
- tc equals the condition under which the next enabled edge wraps. Wire tc of stage n to en of stage n+1 for cascading instances.
- Latency: q reflects clr/load/count one edge after sampling. tc is zero-latency from en, up and q.
- Out-of-range digit values are unreachable except via reset glitches. If present, the count logic treats them as MODULUS-1 on the next increment (rolls to 0). They must never propagate beyond one count.
- All arithmetic is per-digit at DIGIT_W bits; there are no carries between slices other than the ripple-enable rule.

Test Plan:
Defaults apply: MODULUS=10, DIGIT_W=4, DIGITS=2.
- Release reset, en=1, up=1 for 100 edges -> q steps 0x00,0x01..0x09,0x10..0x99,0x00; tc=1 only while q=0x99; wrap=1 exactly one cycle after the 0x99->0x00 edge.
- From q=0x00, en=1, up=0 -> q=0x99 next edge with wrap=1, then 0x98, 0x97; tc=1 only at q=0x00.
- load=1, din=0x57 -> q=0x57; en=1, up=1 -> 0x58, 0x59, 0x60. Then load din=0xA3 -> q=0x03 (invalid tens digit forced to 0).
- At q=0x42, assert clr=1 and load=1 (din=0x88) together -> q=0x00. Next edge with en=0 -> q holds 0x00 and tc=0.
- Count to q=0x35, pull reset low mid-cycle (between edges) -> q=0x00 and wrap=0 without a clock edge. Hold for 3 edges -> stays 0x00. Release -> counting resumes from 0x01.
- Parameter sweep MODULUS=6, DIGITS=3 (DIGIT_W=3): up-count from 0 -> 555 (octal-style digits) then wrap to 000 with wrap pulse after 216 edges.
